// File: rtl/adc_lcd_pkg.sv
// Shared definitions for the ADC-to-LCD character path.
//   - ASCII and LCD command byte constants
//   - fmt_state_t: state encoding of the ASCII formatter
package adc_lcd_pkg;

    localparam logic [7:0] ASCII_0   = 8'h30;
    localparam logic [7:0] ASCII_DOT = 8'h2E;
    localparam logic [7:0] ASCII_V   = 8'h56;

    localparam logic [7:0] LCD_LINE1 = 8'h80;
    localparam logic [7:0] LCD_LINE2 = 8'hC0;
    localparam logic [7:0] LCD_CLEAR = 8'h01;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StScale = 2'd1,
        StBcd   = 2'd2,
        StEmit  = 2'd3
    } fmt_state_t;

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble binary-to-BCD converter, one shift per clock.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       one-cycle pulse; bin is sampled on this edge
//   bin         unsigned binary input
//   done        one-cycle pulse in the cycle after the last shift
//   bcd         packed BCD digits, most significant digit in the top nibble;
//               held stable until the next start
module bin2bcd_serial #(
    parameter int unsigned BIN_BITS = 14,
    parameter int unsigned DIGITS   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_BITS-1:0]   bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned CntW = $clog2(BIN_BITS + 1);

    logic [BIN_BITS-1:0] bin_q, bin_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d, adj_bcd;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                act_q, act_d;
    logic                done_q, done_d;

    // Add-3 correction applied to every nibble before it is shifted.
    always_comb begin
        adj_bcd = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            adj_bcd[4*i +: 4] = bcd_q[4*i +: 4] + ((bcd_q[4*i +: 4] >= 4'd5) ? 4'd3 : 4'd0);
        end
    end

    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        act_d  = act_q;
        done_d = 1'b0;
        if (start) begin
            // The load edge also performs the first shift: with an all-zero
            // BCD register no correction is needed.
            bcd_d = {{(4*DIGITS-1){1'b0}}, bin[BIN_BITS-1]};
            bin_d = {bin[BIN_BITS-2:0], 1'b0};
            cnt_d = CntW'(1);
            act_d = 1'b1;
        end else if (act_q) begin
            bcd_d = {adj_bcd[4*DIGITS-2:0], bin_q[BIN_BITS-1]};
            bin_d = {bin_q[BIN_BITS-2:0], 1'b0};
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(BIN_BITS - 1)) begin
                act_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            act_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/adc_ascii_formatter.sv
// Converts one raw ADC sample per handshake into a 7-byte LCD stream:
// cursor command, then "d.dddV" in millivolts.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   sample_valid  sample offered
//   sample        raw unsigned ADC code
//   sample_ready  registered, high only while idle
//   char_valid    byte offered to the LCD writer
//   char_data     command or ASCII byte
//   char_rs       0 = command byte, 1 = data byte
//   char_ready    LCD writer accepts the byte
//   busy          high from sample accept until the last beat is accepted
module adc_ascii_formatter
    import adc_lcd_pkg::*;
#(
    parameter int unsigned ADC_BITS = 12,
    parameter int unsigned VREF_MV  = 3300,
    parameter logic [7:0]  LINE_CMD = LCD_LINE2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_valid,
    input  logic [ADC_BITS-1:0] sample,
    output logic                sample_ready,
    output logic                char_valid,
    output logic [7:0]          char_data,
    output logic                char_rs,
    input  logic                char_ready,
    output logic                busy
);

    localparam logic [13:0] VrefW    = 14'(VREF_MV);
    localparam logic [2:0]  LastBeat = 3'd6;

    fmt_state_t          state_q, state_d;
    logic [ADC_BITS-1:0] sample_q, sample_d;
    logic [13:0]         mv_q, mv_d;
    logic                start_q, start_d;
    logic [2:0]          beat_q, beat_d;
    logic                ready_q, ready_d;
    logic                valid_q, valid_d;
    logic [7:0]          data_q, data_d;
    logic                rs_q, rs_d;
    logic                busy_q, busy_d;

    logic [ADC_BITS+13:0] product;
    logic                 bcd_done;
    logic [15:0]          digits;

    assign product = sample_q * VrefW;

    bin2bcd_serial #(
        .BIN_BITS (14),
        .DIGITS   (4)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_q),
        .bin   (mv_q),
        .done  (bcd_done),
        .bcd   (digits)
    );

    function automatic logic [7:0] beat_byte(input logic [2:0] beat, input logic [15:0] d);
        case (beat)
            3'd0:    beat_byte = LINE_CMD;
            3'd1:    beat_byte = ASCII_0 + {4'h0, d[15:12]};
            3'd2:    beat_byte = ASCII_DOT;
            3'd3:    beat_byte = ASCII_0 + {4'h0, d[11:8]};
            3'd4:    beat_byte = ASCII_0 + {4'h0, d[7:4]};
            3'd5:    beat_byte = ASCII_0 + {4'h0, d[3:0]};
            3'd6:    beat_byte = ASCII_V;
            default: beat_byte = 8'h00;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        mv_d     = mv_q;
        start_d  = 1'b0;
        beat_d   = beat_q;
        ready_d  = ready_q;
        valid_d  = valid_q;
        data_d   = data_q;
        rs_d     = rs_q;
        busy_d   = busy_q;
        case (state_q)
            StIdle: begin
                ready_d = 1'b1;
                if (sample_valid && ready_q) begin
                    sample_d = sample;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = StScale;
                end
            end
            StScale: begin
                // Floor of sample * VREF / 2^ADC_BITS.
                mv_d    = 14'(product >> ADC_BITS);
                start_d = 1'b1;
                state_d = StBcd;
            end
            StBcd: begin
                if (bcd_done) begin
                    state_d = StEmit;
                    beat_d  = 3'd0;
                    valid_d = 1'b1;
                    data_d  = beat_byte(3'd0, digits);
                    rs_d    = 1'b0;
                end
            end
            StEmit: begin
                if (valid_q && char_ready) begin
                    if (beat_q == LastBeat) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        beat_d = beat_q + 3'd1;
                        data_d = beat_byte(beat_q + 3'd1, digits);
                        rs_d   = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sample_q <= '0;
            mv_q     <= '0;
            start_q  <= 1'b0;
            beat_q   <= 3'd0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= 8'h00;
            rs_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            mv_q     <= mv_d;
            start_q  <= start_d;
            beat_q   <= beat_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            rs_q     <= rs_d;
            busy_q   <= busy_d;
        end
    end

    assign sample_ready = ready_q;
    assign char_valid   = valid_q;
    assign char_data    = data_q;
    assign char_rs      = rs_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_adc_ascii_formatter.sv
// Bench for adc_ascii_formatter: two instances (3300 mV and 5000 mV full scale)
// share stimulus; every stream is compared against an arithmetic reference.
module tb_adc_ascii_formatter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_valid;
    logic [11:0] sample;
    logic        char_ready;

    logic        sample_ready, char_valid, char_rs, busy;
    logic [7:0]  char_data;
    logic        sample_ready_b, char_valid_b, char_rs_b, busy_b;
    logic [7:0]  char_data_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    adc_ascii_formatter #(
        .ADC_BITS (12),
        .VREF_MV  (3300),
        .LINE_CMD (8'hC0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .sample_ready (sample_ready),
        .char_valid   (char_valid),
        .char_data    (char_data),
        .char_rs      (char_rs),
        .char_ready   (char_ready),
        .busy         (busy)
    );

    adc_ascii_formatter #(
        .ADC_BITS (12),
        .VREF_MV  (5000),
        .LINE_CMD (8'hC0)
    ) dut_5v (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .sample_ready (sample_ready_b),
        .char_valid   (char_valid_b),
        .char_data    (char_data_b),
        .char_rs      (char_rs_b),
        .char_ready   (char_ready),
        .busy         (busy_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Reference: millivolts by plain integer arithmetic, digits by division.
    function automatic logic [7:0] exp_byte(input int vref, input logic [11:0] s, input int b);
        int mv;
        mv = (int'(s) * vref) / 4096;
        case (b)
            0:       return 8'hC0;
            1:       return 8'(48 + (mv / 1000) % 10);
            2:       return 8'h2E;
            3:       return 8'(48 + (mv / 100) % 10);
            4:       return 8'(48 + (mv / 10) % 10);
            5:       return 8'(48 + mv % 10);
            default: return 8'h56;
        endcase
    endfunction

    // Called at a negedge with the DUT idle. stall_beat/stall_len insert
    // backpressure, hold keeps sample_valid high with a changing sample,
    // abort_beat asserts reset while that beat is offered.
    task automatic transact(input logic [11:0] s, input int stall_beat, input int stall_len,
                            input bit hold, input int abort_beat);
        int n;
        logic [7:0] e;
        check_eq("ready_before_accept", sample_ready, 1);
        sample_valid = 1'b1;
        sample       = s;
        char_ready   = 1'b1;
        @(negedge clk);
        check_eq("busy_after_accept", busy, 1);
        check_eq("ready_after_accept", sample_ready, 0);
        if (!hold) sample_valid = 1'b0;
        n = 0;
        while (!char_valid && n < 40) begin
            if (hold) sample = 12'($urandom);
            @(negedge clk);
            n++;
        end
        check_eq("first_valid_latency", n, 16);
        if (!char_valid) return;
        for (int b = 0; b < 7; b++) begin
            e = exp_byte(3300, s, b);
            if (b == stall_beat) begin
                char_ready = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk);
                    check_eq($sformatf("stall_valid_b%0d", b), char_valid, 1);
                    check_eq($sformatf("stall_data_b%0d", b), char_data, e);
                end
                char_ready = 1'b1;
            end
            check_eq($sformatf("data_s%0d_b%0d", s, b), char_data, e);
            check_eq($sformatf("rs_b%0d", b), char_rs, (b != 0));
            check_eq($sformatf("valid_b%0d", b), char_valid, 1);
            check_eq($sformatf("ready_low_b%0d", b), sample_ready, 0);
            check_eq($sformatf("data5v_s%0d_b%0d", s, b), char_data_b, exp_byte(5000, s, b));
            if (b == abort_beat) begin
                rst_n = 1'b0;
                #1;
                check_eq("abort_valid", char_valid, 0);
                check_eq("abort_busy", busy, 0);
                check_eq("abort_ready", sample_ready, 0);
                check_eq("abort_valid_5v", char_valid_b, 0);
                return;
            end
            if (hold) sample = 12'($urandom);
            @(negedge clk);
        end
        check_eq("end_valid", char_valid, 0);
        check_eq("end_busy", busy, 0);
        check_eq("end_ready", sample_ready, 1);
    endtask

    initial begin
        rst_n        = 1'b1;
        sample_valid = 1'b0;
        sample       = '0;
        char_ready   = 1'b0;
        #2 rst_n = 1'b0;
        #10;
        check_eq("rst_ready", sample_ready, 0);
        check_eq("rst_valid", char_valid, 0);
        check_eq("rst_data", char_data, 8'h00);
        check_eq("rst_rs", char_rs, 0);
        check_eq("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_eq("ready_before_first_edge", sample_ready, 0);
        @(negedge clk);
        check_eq("ready_after_reset", sample_ready, 1);

        transact(12'd2048, -1, 0, 1'b0, -1);
        transact(12'd4095, -1, 0, 1'b0, -1);
        transact(12'd0, -1, 0, 1'b0, -1);
        transact(12'd2048, 2, 5, 1'b0, -1);

        // sample_valid held through two conversions: one accept each.
        transact(12'd1234, -1, 0, 1'b1, -1);
        transact(12'd3000, -1, 0, 1'b1, -1);
        sample_valid = 1'b0;

        // Reset while beat 3 is offered, then a clean conversion.
        transact(12'd777, -1, 0, 1'b0, 3);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_eq("ready_low_after_release", sample_ready, 0);
        @(negedge clk);
        check_eq("ready_one_cycle_after_release", sample_ready, 1);
        transact(12'd1024, -1, 0, 1'b0, -1);

        repeat (8) begin
            transact(12'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(1, 4)),
                     1'b0, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adc_ascii_formatter.md
# adc_ascii_formatter

Upstream stage of the LCD character writer. Accepts one raw ADC sample per handshake, scales it to millivolts, converts the result to decimal with a serial double-dabble, and emits a fixed 7-beat stream of LCD bytes. The stream is one cursor command followed by six ASCII characters of the form "d.dddV". The downstream LCD writer consumes one byte per accepted beat and drives lcd_e, lcd_rs and data toward the panel.

## Interface
- ADC_BITS, 12, width of the raw sample
- VREF_MV, 3300, full-scale reference in millivolts; legal range 1..9999
- LINE_CMD, 8'hC0, cursor-position command emitted before the digits (second line, column 0)

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- sample_valid  in  1  sample offered
- sample  in  ADC_BITS  raw unsigned ADC code
- sample_ready  out  1  registered; high only in IDLE
- char_valid  out  1  byte offered to the LCD writer
- char_data  out  8  command or ASCII byte
- char_rs  out  1  0 = command byte, 1 = data byte
- char_ready  in  1  LCD writer accepts the byte
- busy  out  1  high from sample accept until the last beat is accepted

## Operation
- **States:** IDLE, SCALE, BCD, EMIT.
- **IDLE:** sample_ready=1. On sample_valid && sample_ready, latch sample and go to SCALE.
- **SCALE:** one cycle.
  - Compute mv = (sample * VREF_MV) >> ADC_BITS. Result is unsigned and truncated (floor).
  - The product is ADC_BITS+14 bits wide; mv is 14 bits.
  - Go to BCD.
- **BCD:** 14 cycles of double-dabble, one shift per cycle.
  - Before each shift, every BCD nibble that is ≥5 gets +3.
  - Produces digits d3 (thousands), d2, d1, d0.
  - After the 14th shift, go to EMIT with beat index 0.
- **EMIT:** 7 beats, in this order:
  - Beat 0: LINE_CMD, rs=0.
  - Beat 1: 8'h30+d3.
  - Beat 2: 8'h2E ('.').
  - Beats 3–5: 8'h30+d2, 8'h30+d1, 8'h30+d0.
  - Beat 6: 8'h56 ('V').
  - Beats 1–6 have rs=1.
- **Leading digit:** d3 is always printed, including '0'.
- **Beat transfer:** a beat completes on char_valid && char_ready.
  - char_data and char_rs stay stable while char_valid=1 and char_ready=0.
  - char_valid never drops before the beat is accepted.
- **Completion:** after beat 6 is accepted, return to IDLE.
- **No buffering:** samples offered while busy are not accepted. Upstream must hold them or drop them.
- **Reset mid-operation:** an asynchronous reset in any state aborts immediately. The partial stream is discarded, with no completion beat.

## Timing
- Reset values:
  - state=IDLE, sample_ready=0, char_valid=0, char_data=8'h00, char_rs=0, busy=0.
  - Internal sample, mv and BCD registers = 0.
  - sample_ready rises on the first clk edge after rst_n deasserts.
- **Cycle 0:** sample accepted (the edge where sample_valid && sample_ready). Registered outputs change after this edge:
  - sample_ready falls.
  - busy rises.
- **Cycle 1:** SCALE.
- **Cycles 2–15:** BCD.
- **Cycle 16:** char_valid=1 with beat 0.
- **Throughput:** with char_ready tied high, beats occupy cycles 16–22 and the next sample can be accepted at cycle 24. Minimum 24 cycles per sample.
- **Back-to-back beats:** when a beat is accepted, the next beat is presented in the following cycle with no bubble.
- **End of stream:** busy and char_valid fall together on the edge that accepts beat 6; sample_ready rises on that same edge.
- **Simultaneous events:** sample_valid during EMIT has no effect. char_ready while char_valid=0 is ignored.

## Structure
- **Shared package adc_lcd_pkg:**
  - ASCII constants: ASCII_0=8'h30, ASCII_DOT=8'h2E, ASCII_V=8'h56.
  - LCD command constants: LCD_LINE1=8'h80, LCD_LINE2=8'hC0, LCD_CLEAR=8'h01.
  - The fmt_state_t enum.
- **Sub-module bin2bcd_serial:**
  - Parameters: 14-bit input, 4 digits.
  - Handshake: start pulse in, done pulse out.
  - Timing: 14-cycle latency, done in the cycle after the last shift.
- **Top level:** the top-level module holds the handshake, the scaling multiply and the beat sequencer.

## Test plan
- sample=12'd2048, char_ready=1 → bytes C0,31,2E,36,35,30,56; rs pattern 0,1,1,1,1,1,1; first char_valid exactly 16 cycles after accept.
- sample=12'd4095 → mv=3299 → C0,33,2E,32,39,39,56. Repeat with sample=0 → C0,30,2E,30,30,30,56 (leading zero printed).
- Backpressure: char_ready low for 5 cycles while beat 2 is offered → char_data stays 8'h2E and char_valid stays 1; the stream resumes in order with no lost or duplicated byte.
- sample_valid held high through a whole conversion with a changing sample value → exactly one accept; a second accept occurs only in the cycle after beat 6 is accepted.
- rst_n asserted during beat 3 → char_valid=0 and busy=0 immediately; after release, sample_ready=1 one cycle later and a new sample 12'd1024 yields C0,30,2E,38,32,35,56 (mv=825).
- Parameter sweep VREF_MV=5000, sample=12'd4095 → mv=4998 → C0,34,2E,39,39,38,56.
